// File: rtl/traffic_light_pkg.sv
// Shared phase/state encodings and helpers for the traffic light monitor.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_NONE   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_TRACK_R = 2'd1,
    ST_TRACK_G = 2'd2,
    ST_TRACK_Y = 2'd3
  } state_e;

  // The controller holds each light for its TIME parameter plus one sample.
  function automatic int exp_dwell(phase_e ph, int red_t, int green_t, int yellow_t);
    int d;
    case (ph)
      PH_RED:    d = red_t + 32'sd1;
      PH_GREEN:  d = green_t + 32'sd1;
      PH_YELLOW: d = yellow_t + 32'sd1;
      default:   d = 32'sd0;
    endcase
    return d;
  endfunction

  function automatic phase_e next_phase(phase_e ph);
    phase_e n;
    case (ph)
      PH_RED:    n = PH_GREEN;
      PH_GREEN:  n = PH_YELLOW;
      PH_YELLOW: n = PH_RED;
      default:   n = PH_NONE;
    endcase
    return n;
  endfunction

  function automatic state_e phase_state(phase_e ph);
    state_e s;
    case (ph)
      PH_RED:    s = ST_TRACK_R;
      PH_GREEN:  s = ST_TRACK_G;
      PH_YELLOW: s = ST_TRACK_Y;
      default:   s = ST_UNSYNC;
    endcase
    return s;
  endfunction

  // Only meaningful when exactly one light is on.
  function automatic phase_e light_phase(logic r, logic g);
    phase_e p;
    if (r) begin
      p = PH_RED;
    end else if (g) begin
      p = PH_GREEN;
    end else begin
      p = PH_YELLOW;
    end
    return p;
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter: clear to 0, load 1 on phase entry, or increment.
module tl_dwell_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next count; holds at all-ones so a long phase never wraps back to small values.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = W'(1);
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of red/yellow/green: one-hot, R->G->Y->R order and dwell time.
// Define TLM_ERR_CLEAR_EN to add err_clr, which clears err_sticky without reset.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_TIME    = 5,
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2,
  parameter int TOL         = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
`ifdef TLM_ERR_CLEAR_EN
  input  logic        err_clr,
`endif
  output logic [1:0]  cur_phase,
  output logic        locked,
  output logic        err_onehot,
  output logic        err_seq,
  output logic        err_dwell,
  output logic        err_sticky,
  output logic [15:0] cycles_ok
);

  localparam int MAX_RG   = (RED_TIME > GREEN_TIME) ? RED_TIME : GREEN_TIME;
  localparam int MAX_TIME = (MAX_RG > YELLOW_TIME) ? MAX_RG : YELLOW_TIME;
  localparam int DW       = $clog2(MAX_TIME + TOL + 3);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d, in_ph_s;
  logic          locked_d, first_q, first_d, ovr_q, ovr_d, clean_q, clean_d;
  logic          err_onehot_d, err_seq_d, err_dwell_d, err_sticky_d;
  logic [15:0]   cycles_d;
  logic          onehot_s, clr_s, chk_fail_s, dwell_ok_s;
  logic          cnt_clr_s, cnt_load_s, cnt_inc_s;
  logic [DW-1:0] dwell_s;
  int            dwell_int_s, dwell_next_s, exp_cur_s, limit_s;

`ifdef TLM_ERR_CLEAR_EN
  assign clr_s = err_clr;
`else
  assign clr_s = 1'b0;
`endif

  assign onehot_s     = (red ^ yellow ^ green) & ~(red & yellow & green);
  assign in_ph_s      = light_phase(red, green);
  assign exp_cur_s    = exp_dwell(phase_q, RED_TIME, GREEN_TIME, YELLOW_TIME);
  assign limit_s      = exp_cur_s + TOL + 32'sd1;
  assign dwell_int_s  = int'(dwell_s);
  // Mirrors the counter's saturation so the overrun threshold is hit exactly once.
  assign dwell_next_s = (dwell_s == {DW{1'b1}}) ? dwell_int_s : dwell_int_s + 32'sd1;
  assign dwell_ok_s   = ((dwell_int_s - exp_cur_s) <= TOL) && ((exp_cur_s - dwell_int_s) <= TOL);

  tl_dwell_counter #(.W(DW)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr_s),
    .load_i  (cnt_load_s),
    .inc_i   (cnt_inc_s),
    .count_o (dwell_s)
  );

  // Decode one input sample into next state, error pulses and counter controls.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    locked_d     = locked;
    first_d      = first_q;
    ovr_d        = ovr_q;
    clean_d      = clean_q;
    cycles_d     = cycles_ok;
    err_onehot_d = 1'b0;
    err_seq_d    = 1'b0;
    err_dwell_d  = 1'b0;
    chk_fail_s   = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_inc_s    = 1'b0;
    if (!onehot_s) begin
      err_onehot_d = 1'b1;
      state_d      = ST_UNSYNC;
      phase_d      = PH_NONE;
      locked_d     = 1'b0;
      clean_d      = 1'b0;
      cnt_clr_s    = 1'b1;
    end else if (state_q == ST_UNSYNC) begin
      // First phase after sync may be partial, so it is never dwell-checked.
      state_d    = phase_state(in_ph_s);
      phase_d    = in_ph_s;
      locked_d   = 1'b1;
      first_d    = 1'b1;
      ovr_d      = 1'b0;
      clean_d    = 1'b0;
      cnt_load_s = 1'b1;
    end else if (in_ph_s == phase_q) begin
      cnt_inc_s = 1'b1;
      if (!first_q && !ovr_q && (dwell_next_s == limit_s)) begin
        err_dwell_d = 1'b1;
        ovr_d       = 1'b1;
        clean_d     = 1'b0;
      end else begin
        err_dwell_d = 1'b0;
      end
    end else if (in_ph_s == next_phase(phase_q)) begin
      chk_fail_s  = !first_q && !ovr_q && !dwell_ok_s;
      err_dwell_d = chk_fail_s;
      if (phase_q == PH_YELLOW) begin
        cycles_d = (clean_q && !chk_fail_s) ? cycles_ok + 16'd1 : cycles_ok;
        clean_d  = 1'b1;
      end else begin
        clean_d  = clean_q && !chk_fail_s;
      end
      state_d    = phase_state(in_ph_s);
      phase_d    = in_ph_s;
      first_d    = 1'b0;
      ovr_d      = 1'b0;
      cnt_load_s = 1'b1;
    end else begin
      err_seq_d  = 1'b1;
      state_d    = phase_state(in_ph_s);
      phase_d    = in_ph_s;
      first_d    = 1'b1;
      ovr_d      = 1'b0;
      clean_d    = 1'b0;
      cnt_load_s = 1'b1;
    end
    // A fresh pulse outranks a clear request.
    err_sticky_d = err_onehot_d | err_seq_d | err_dwell_d | (err_sticky & ~clr_s);
  end

  // Tracker state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_UNSYNC;
      phase_q    <= PH_NONE;
      locked     <= 1'b0;
      first_q    <= 1'b0;
      ovr_q      <= 1'b0;
      clean_q    <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_dwell  <= 1'b0;
      err_sticky <= 1'b0;
      cycles_ok  <= 16'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      locked     <= locked_d;
      first_q    <= first_d;
      ovr_q      <= ovr_d;
      clean_q    <= clean_d;
      err_onehot <= err_onehot_d;
      err_seq    <= err_seq_d;
      err_dwell  <= err_dwell_d;
      err_sticky <= err_sticky_d;
      cycles_ok  <= cycles_d;
    end
  end

  assign cur_phase = phase_q;

endmodule
